// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Time-multiplexed scan controller for an N-digit common-anode
//               seven-segment display. Each digit owns a slot of SCAN_DIV+1
//               clocks. The first BLANK_CYCLES clocks of every slot keep all
//               anodes off to suppress ghosting. Hex nibbles are decoded to
//               active-low segments. New display values arrive through a
//               load_req/load_ack handshake. They land in a shadow register
//               only at a frame wrap, or at any edge while idle, so a frame
//               never mixes old and new values.
//
//               Optional build macro: LEADING_ZERO_BLANK_EN. When defined,
//               leading zero digits (from the top digit downward) are
//               suppressed. Digit 0 is always shown.
//
// Ports       : clk         system clock
//               rst         synchronous active-high reset
//               enable      1 = scan display, 0 = display off (idle)
//               value_in    hex nibbles; nibble k drives digit k (0 = right)
//               load_req    request to latch value_in, held until load_ack
//               load_ack    one-cycle pulse after value_in was latched
//               an          anodes, active-low
//               seg         segments {g,f,e,d,c,b,a}, active-low
//               digit_idx   index of the current digit slot
//               frame_done  one-cycle pulse after the frame wrapped to digit 0
//
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 49999,
    parameter int BLANK_CYCLES = 100
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    enable,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load_req,
    output logic                    load_ack,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic [2:0]              digit_idx,
    output logic                    frame_done
);

    localparam int CW = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_blank = 2'd1;
    localparam logic [1:0] c_st_show  = 2'd2;

    localparam logic [CW-1:0] c_scan_last  = CW'(SCAN_DIV);
    localparam logic [2:0]    c_last_digit = 3'(NUM_DIGITS - 1);
    localparam logic [31:0]   c_blank      = 32'(BLANK_CYCLES);
    // State entered at the start of every slot.
    localparam logic [1:0]    c_slot_start = (BLANK_CYCLES == 0) ? c_st_show : c_st_blank;

    logic [1:0]              r_state;
    logic [CW-1:0]           r_count;
    logic [2:0]              r_idx;
    logic [4*NUM_DIGITS-1:0] r_shadow;
    logic                    r_ack;
    logic                    r_frame_done;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [6:0]              r_seg;

    logic [1:0]              w_state_nxt;
    logic [CW-1:0]           w_count_nxt;
    logic [2:0]              w_idx_nxt;
    logic [4*NUM_DIGITS-1:0] w_shadow_nxt;
    logic                    w_ack_nxt;
    logic                    w_frame_done_nxt;
    logic [NUM_DIGITS-1:0]   w_an_nxt;
    logic [6:0]              w_seg_nxt;

    logic [CW-1:0]           w_count_inc;
    logic                    w_slot_end;
    logic                    w_frame_end;
    logic [4*NUM_DIGITS-1:0] w_nib_shift;
    logic [NUM_DIGITS-1:0]   w_suppress;
    logic [NUM_DIGITS-1:0]   w_supp_shift;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        case (h)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign w_count_inc = r_count + CW'(1);
    assign w_slot_end  = (r_count == c_scan_last);
    assign w_frame_end = w_slot_end && (r_idx == c_last_digit);

    // ------------------------------------------------------------------
    // Next-state logic: scan sequencing and shadow-register loading
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = r_state;
        w_count_nxt      = r_count;
        w_idx_nxt        = r_idx;
        w_shadow_nxt     = r_shadow;
        w_ack_nxt        = 1'b0;
        w_frame_done_nxt = 1'b0;

        if (r_state == c_st_idle) begin
            if (load_req) begin
                w_shadow_nxt = value_in;
                w_ack_nxt    = 1'b1;
            end
            if (enable) begin
                w_state_nxt = c_slot_start;
                w_count_nxt = '0;
                w_idx_nxt   = 3'd0;
            end
        end else begin
            // The frame wrap edge is the only point where a running display
            // accepts new values; this holds even when enable drops on it.
            if (w_frame_end && load_req) begin
                w_shadow_nxt = value_in;
                w_ack_nxt    = 1'b1;
            end
            if (!enable) begin
                // Abandon the current slot immediately. The frame is not
                // completed, so frame_done stays low.
                w_state_nxt = c_st_idle;
                w_count_nxt = '0;
                w_idx_nxt   = 3'd0;
            end else if (w_slot_end) begin
                w_state_nxt      = c_slot_start;
                w_count_nxt      = '0;
                w_idx_nxt        = w_frame_end ? 3'd0 : (r_idx + 3'd1);
                w_frame_done_nxt = w_frame_end;
            end else begin
                w_count_nxt = w_count_inc;
                w_state_nxt = (32'(w_count_inc) < c_blank) ? c_st_blank : c_st_show;
            end
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression mask, built from the upcoming shadow value
    // so it always matches the digit being displayed.
    // ------------------------------------------------------------------
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        logic lead_zero;
        lead_zero  = 1'b1;
        w_suppress = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            lead_zero     = lead_zero && (w_shadow_nxt[4*k +: 4] == 4'h0);
            w_suppress[k] = lead_zero && (k != 0);
        end
    end
`else
    assign w_suppress = '0;
`endif

    // ------------------------------------------------------------------
    // Output drive, computed from the next state so the registered anode
    // and segment outputs line up with the registered state.
    // ------------------------------------------------------------------
    assign w_nib_shift  = w_shadow_nxt >> {w_idx_nxt, 2'b00};
    assign w_supp_shift = w_suppress >> w_idx_nxt;

    always_comb begin
        w_an_nxt  = {NUM_DIGITS{1'b1}};
        w_seg_nxt = 7'h7F;
        if ((w_state_nxt == c_st_show) && !w_supp_shift[0]) begin
            w_an_nxt  = {NUM_DIGITS{1'b1}} ^ (NUM_DIGITS'(1) << w_idx_nxt);
            w_seg_nxt = hex_to_seg(w_nib_shift[3:0]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_count      <= '0;
            r_idx        <= 3'd0;
            r_shadow     <= '0;
            r_ack        <= 1'b0;
            r_frame_done <= 1'b0;
            r_an         <= {NUM_DIGITS{1'b1}};
            r_seg        <= 7'h7F;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_idx        <= w_idx_nxt;
            r_shadow     <= w_shadow_nxt;
            r_ack        <= w_ack_nxt;
            r_frame_done <= w_frame_done_nxt;
            r_an         <= w_an_nxt;
            r_seg        <= w_seg_nxt;
        end
    end

    assign load_ack   = r_ack;
    assign an         = r_an;
    assign seg        = r_seg;
    assign digit_idx  = r_idx;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_ctrl
// Description : Directed self-checking bench for seven_seg_scan_ctrl with
//               NUM_DIGITS=4, SCAN_DIV=9, BLANK_CYCLES=2. Expected values are
//               hand-computed constants. Leading-zero expectations follow the
//               LEADING_ZERO_BLANK_EN build macro.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

    localparam int NUM_DIGITS   = 4;
    localparam int SCAN_DIV     = 9;
    localparam int BLANK_CYCLES = 2;
    localparam int SLOT         = SCAN_DIV + 1;
    localparam int FRAME        = SLOT * NUM_DIGITS;

    localparam logic [6:0] c_seg_off = 7'h7F;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] value_in;
    logic        load_req;
    logic        load_ack;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic [2:0]  digit_idx;
    logic        frame_done;

    int n_checks = 0;
    int n_fails  = 0;
    int pos      = 0;   // slot-relative position: digit*SLOT + count

    seven_seg_scan_ctrl #(
        .NUM_DIGITS  (NUM_DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .enable    (enable),
        .value_in  (value_in),
        .load_req  (load_req),
        .load_ack  (load_ack),
        .an        (an),
        .seg       (seg),
        .digit_idx (digit_idx),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Move forward to digit d, count c of the running scan.
    task automatic go(input int d, input int c);
        int target;
        target = d * SLOT + c;
        ticks((target - pos + FRAME) % FRAME);
        pos = target;
    endtask

    task automatic expect_disp(input string tag, input logic [3:0] an_exp,
                               input logic [6:0] seg_exp, input logic [2:0] idx_exp);
        chk({tag, "_an"},  32'(an),        32'(an_exp));
        chk({tag, "_seg"}, 32'(seg),       32'(seg_exp));
        chk({tag, "_idx"}, 32'(digit_idx), 32'(idx_exp));
    endtask

    // Stop, load a value while idle, and restart at digit 0 count 0.
    task automatic reload(input logic [15:0] v, input string tag);
        enable = 1'b0;
        tick();
        load_req = 1'b1;
        value_in = v;
        tick();
        chk({tag, "_ack"}, 32'(load_ack), 32'd1);
        load_req = 1'b0;
        enable   = 1'b1;
        tick();
        pos = 0;
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        value_in = 16'h0000;
        load_req = 1'b0;

        // 1. reset state
        for (int i = 0; i < 2; i++) begin
            tick();
            expect_disp("rst", 4'b1111, c_seg_off, 3'd0);
            chk("rst_ack", 32'(load_ack), 32'd0);
            chk("rst_fd",  32'(frame_done), 32'd0);
        end

        // 2. idle load then scan 12AF
        rst      = 1'b0;
        enable   = 1'b0;
        load_req = 1'b1;
        value_in = 16'h12AF;
        tick();
        chk("idle_ack", 32'(load_ack), 32'd1);
        load_req = 1'b0;
        tick();
        chk("idle_ack_low", 32'(load_ack), 32'd0);
        enable = 1'b1;
        tick();
        pos = 0;
        expect_disp("s0c0", 4'b1111, c_seg_off, 3'd0);
        go(0, 1); expect_disp("s0c1", 4'b1111, c_seg_off, 3'd0);
        go(0, 2); expect_disp("s0c2", 4'b1110, 7'b0001110, 3'd0);
        go(0, 9); expect_disp("s0c9", 4'b1110, 7'b0001110, 3'd0);
        go(1, 0); expect_disp("s1c0", 4'b1111, c_seg_off, 3'd1);
        chk("s1c0_fd", 32'(frame_done), 32'd0);
        go(1, 2); expect_disp("s1c2", 4'b1101, 7'b0001000, 3'd1);
        go(2, 2); expect_disp("s2c2", 4'b1011, 7'b0100100, 3'd2);
        go(3, 2); expect_disp("s3c2", 4'b0111, 7'b1111001, 3'd3);
        go(0, 0);
        chk("wrap_fd", 32'(frame_done), 32'd1);
        chk("wrap_noack", 32'(load_ack), 32'd0);

        // 3. load during digit 1 waits for the frame wrap
        go(1, 3);
        load_req = 1'b1;
        value_in = 16'h8888;
        go(2, 2); expect_disp("old_s2", 4'b1011, 7'b0100100, 3'd2);
        go(3, 2); expect_disp("old_s3", 4'b0111, 7'b1111001, 3'd3);
        go(3, 9);
        chk("pre_wrap_ack", 32'(load_ack), 32'd0);
        go(0, 0);
        chk("wrap_ack", 32'(load_ack), 32'd1);
        chk("wrap_fd2", 32'(frame_done), 32'd1);
        load_req = 1'b0;
        go(0, 1);
        chk("ack_pulse", 32'(load_ack), 32'd0);
        chk("fd_pulse",  32'(frame_done), 32'd0);
        go(0, 2); expect_disp("new_s0", 4'b1110, 7'b0000000, 3'd0);

        // 4. disable mid-slot
        go(2, 5); expect_disp("s2c5", 4'b1011, 7'b0000000, 3'd2);
        enable = 1'b0;
        tick();
        expect_disp("dis", 4'b1111, c_seg_off, 3'd0);
        enable = 1'b1;
        tick();
        pos = 0;
        expect_disp("re_c0", 4'b1111, c_seg_off, 3'd0);
        go(0, 1); expect_disp("re_c1", 4'b1111, c_seg_off, 3'd0);
        go(0, 2); expect_disp("re_c2", 4'b1110, 7'b0000000, 3'd0);

        // 5. reset with a pending request
        go(3, 4);
        load_req = 1'b1;
        value_in = 16'h3C07;
        rst      = 1'b1;
        tick();
        expect_disp("rst2", 4'b1111, c_seg_off, 3'd0);
        chk("rst2_ack", 32'(load_ack), 32'd0);
        tick();
        chk("rst2_ack_b", 32'(load_ack), 32'd0);
        rst    = 1'b0;
        enable = 1'b0;
        tick();
        chk("post_rst_ack", 32'(load_ack), 32'd1);
        load_req = 1'b0;
        tick();
        chk("post_rst_ack_low", 32'(load_ack), 32'd0);
        enable = 1'b1;
        tick();
        pos = 0;
        go(0, 2); expect_disp("v_s0", 4'b1110, 7'b1111000, 3'd0);
        go(1, 2); expect_disp("v_s1", 4'b1101, 7'b1000000, 3'd1);
        go(2, 2); expect_disp("v_s2", 4'b1011, 7'b1000110, 3'd2);
        go(3, 2); expect_disp("v_s3", 4'b0111, 7'b0110000, 3'd3);

        // 6. leading-zero behaviour
        reload(16'h0045, "lz45");
`ifdef LEADING_ZERO_BLANK_EN
        go(2, 2); expect_disp("lz45_s2", 4'b1111, c_seg_off, 3'd2);
        go(3, 2); expect_disp("lz45_s3", 4'b1111, c_seg_off, 3'd3);
        go(3, 9); expect_disp("lz45_s3e", 4'b1111, c_seg_off, 3'd3);
`else
        go(2, 2); expect_disp("lz45_s2", 4'b1011, 7'b1000000, 3'd2);
        go(3, 2); expect_disp("lz45_s3", 4'b0111, 7'b1000000, 3'd3);
        go(3, 9); expect_disp("lz45_s3e", 4'b0111, 7'b1000000, 3'd3);
`endif
        go(0, 0);
        chk("lz45_fd", 32'(frame_done), 32'd1);
        go(0, 2); expect_disp("lz45_s0", 4'b1110, 7'b0010010, 3'd0);
        go(1, 2); expect_disp("lz45_s1", 4'b1101, 7'b0011001, 3'd1);

        reload(16'h0000, "lz00");
        go(0, 2); expect_disp("lz00_s0", 4'b1110, 7'b1000000, 3'd0);
`ifdef LEADING_ZERO_BLANK_EN
        go(1, 2); expect_disp("lz00_s1", 4'b1111, c_seg_off, 3'd1);
        go(2, 2); expect_disp("lz00_s2", 4'b1111, c_seg_off, 3'd2);
        go(3, 2); expect_disp("lz00_s3", 4'b1111, c_seg_off, 3'd3);
`else
        go(1, 2); expect_disp("lz00_s1", 4'b1101, 7'b1000000, 3'd1);
        go(2, 2); expect_disp("lz00_s2", 4'b1011, 7'b1000000, 3'd2);
        go(3, 2); expect_disp("lz00_s3", 4'b0111, 7'b1000000, 3'd3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
